// File: rtl/io_port_ctrl.sv
// Memory-mapped multi-port GPIO controller: per-port output register, input-change
// FIFO, sticky change/overflow flags (W1C) and a masked, registered interrupt.
module io_port_ctrl #(
  parameter int IO_PORTS   = 4,
  parameter int PORT_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  io_addr,
  input  logic                         io_write,
  input  logic                         io_read,
  input  logic [31:0]                  io_wdata,
  output logic [31:0]                  io_rdata,
  output logic                         io_irq,
  input  logic [IO_PORTS*PORT_W-1:0]   io_in,
  output logic [IO_PORTS*PORT_W-1:0]   io_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_DATA_IN  = 2'd0,
    REG_DATA_OUT = 2'd1,
    REG_CONTROL  = 2'd2,
    REG_STATUS   = 2'd3
  } reg_e;

  logic [PORT_W-1:0]          r_fifo [IO_PORTS][FIFO_DEPTH];
  logic [AW-1:0]              r_wp   [IO_PORTS];
  logic [AW-1:0]              r_rp   [IO_PORTS];
  logic [CW-1:0]              r_cnt  [IO_PORTS];
  logic [PORT_W-1:0]          r_dout [IO_PORTS];
  logic [PORT_W-1:0]          r_prev [IO_PORTS];
  logic [3:0]                 r_ctrl [IO_PORTS];
  logic [IO_PORTS-1:0]        r_ovf;
  logic [IO_PORTS-1:0]        r_chg;
  logic [31:0]                r_rdata;
  logic                       r_irq;
  logic [IO_PORTS*PORT_W-1:0] r_out;

  logic [3:0]          w_port;
  reg_e                w_reg;
  logic                w_mapped;
  logic                w_rd;
  logic [IO_PORTS-1:0] w_sel;
  logic [IO_PORTS-1:0] w_pop;
  logic [IO_PORTS-1:0] w_chg_set;
  logic [IO_PORTS-1:0] w_push;
  logic [IO_PORTS-1:0] w_ovf_set;
  logic [IO_PORTS-1:0] w_ovf_clr;
  logic [IO_PORTS-1:0] w_chg_clr;
  logic [IO_PORTS-1:0] w_irq_src;
  logic [PORT_W-1:0]   w_in       [IO_PORTS];
  logic [PORT_W-1:0]   w_dout_nxt [IO_PORTS];
  logic [3:0]          w_ctrl_nxt [IO_PORTS];
  logic [PORT_W-1:0]   w_out_nxt  [IO_PORTS];
  logic [3:0]          w_cnt_disp [IO_PORTS];
  logic [31:0]         w_rdata;
  logic                w_unused;

  assign w_port   = io_addr[7:4];
  assign w_reg    = reg_e'(io_addr[3:2]);
  assign w_mapped = (io_addr[31:8] == '0) && (io_addr[1:0] == 2'b00) &&
                    ({28'd0, w_port} < 32'(IO_PORTS));
  // A simultaneous write takes priority and suppresses the read entirely.
  assign w_rd     = io_read && !io_write;
  assign w_unused = &{1'b0, io_wdata};

  always_comb begin
    for (int unsigned p = 0; p < IO_PORTS; p++) begin
      w_in[p]       = io_in[p*PORT_W +: PORT_W];
      w_sel[p]      = w_mapped && ({28'd0, w_port} == p);
      w_pop[p]      = w_rd && w_sel[p] && (w_reg == REG_DATA_IN) && (r_cnt[p] != '0);
      w_chg_set[p]  = r_ctrl[p][1] && (w_in[p] != r_prev[p]);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      w_push[p]     = w_chg_set[p] && ((r_cnt[p] != FULL_CNT) || w_pop[p]);
      w_ovf_set[p]  = w_chg_set[p] && (r_cnt[p] == FULL_CNT) && !w_pop[p];
      w_ovf_clr[p]  = io_write && w_sel[p] && (w_reg == REG_STATUS) && io_wdata[2];
      w_chg_clr[p]  = io_write && w_sel[p] && (w_reg == REG_STATUS) && io_wdata[3];
      w_irq_src[p]  = (r_chg[p] && r_ctrl[p][2]) || (r_ovf[p] && r_ctrl[p][3]);
      w_dout_nxt[p] = (io_write && w_sel[p] && (w_reg == REG_DATA_OUT)) ?
                      io_wdata[PORT_W-1:0] : r_dout[p];
      w_ctrl_nxt[p] = (io_write && w_sel[p] && (w_reg == REG_CONTROL)) ?
                      io_wdata[3:0] : r_ctrl[p];
      w_out_nxt[p]  = w_ctrl_nxt[p][0] ? w_dout_nxt[p] : '0;
      w_cnt_disp[p] = (32'(r_cnt[p]) > 32'd15) ? 4'hF : 4'(r_cnt[p]);
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned p = 0; p < IO_PORTS; p++) begin
      if (w_sel[p]) begin
        case (w_reg)
          REG_DATA_IN:  if (r_cnt[p] != '0) w_rdata[PORT_W-1:0] = r_fifo[p][r_rp[p]];
          REG_DATA_OUT: w_rdata[PORT_W-1:0] = r_dout[p];
          REG_CONTROL:  w_rdata[3:0] = r_ctrl[p];
          REG_STATUS:   w_rdata[7:0] = {w_cnt_disp[p], r_chg[p], r_ovf[p],
                                        (r_cnt[p] == FULL_CNT), (r_cnt[p] != '0)};
          default:      w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 0; p < IO_PORTS; p++) begin
        for (int unsigned d = 0; d < FIFO_DEPTH; d++) r_fifo[p][d] <= '0;
        r_wp[p]   <= '0;
        r_rp[p]   <= '0;
        r_cnt[p]  <= '0;
        r_dout[p] <= '0;
        r_prev[p] <= '0;
        r_ctrl[p] <= '0;
      end
      r_ovf   <= '0;
      r_chg   <= '0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
      r_out   <= '0;
    end else begin
      if (w_rd) r_rdata <= w_rdata;
      r_irq <= |w_irq_src;
      for (int unsigned p = 0; p < IO_PORTS; p++) begin
        r_prev[p] <= w_in[p];
        if (w_push[p]) begin
          r_fifo[p][r_wp[p]] <= w_in[p];
          r_wp[p]            <= r_wp[p] + 1'b1;
        end
        if (w_pop[p]) r_rp[p] <= r_rp[p] + 1'b1;
        case ({w_push[p], w_pop[p]})
          2'b10:   r_cnt[p] <= r_cnt[p] + 1'b1;
          2'b01:   r_cnt[p] <= r_cnt[p] - 1'b1;
          default: r_cnt[p] <= r_cnt[p];
        endcase
        r_ovf[p]  <= (r_ovf[p] && !w_ovf_clr[p]) || w_ovf_set[p];
        r_chg[p]  <= (r_chg[p] && !w_chg_clr[p]) || w_chg_set[p];
        r_dout[p] <= w_dout_nxt[p];
        r_ctrl[p] <= w_ctrl_nxt[p];
        r_out[p*PORT_W +: PORT_W] <= w_out_nxt[p];
      end
    end
  end

  assign io_rdata = r_rdata;
  assign io_irq   = r_irq;
  assign io_out   = r_out;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus random traffic, with read data
// checked through a scoreboard fed by a behavioural model of the register map.
module tb_io_port_ctrl;
  localparam int NP = 4;
  localparam int PW = 8;
  localparam int FD = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        io_addr, io_wdata, io_rdata;
  logic               io_write, io_read, io_irq;
  logic [NP*PW-1:0]   io_in, io_out;

  io_port_ctrl #(.IO_PORTS(NP), .PORT_W(PW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_write(io_write),
    .io_read(io_read), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .io_irq(io_irq), .io_in(io_in), .io_out(io_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: FIFO kept as a shift list, head at index 0.
  logic [PW-1:0]    m_fifo [NP][FD];
  int               m_cnt  [NP];
  logic [PW-1:0]    m_dout [NP];
  logic [PW-1:0]    m_prev [NP];
  logic [3:0]       m_ctrl [NP];
  logic             m_ovf  [NP];
  logic             m_chg  [NP];
  logic [NP*PW-1:0] m_out;
  logic             m_irq;
  logic [31:0]      m_rdata;
  logic [NP*PW-1:0] cur_in;
  logic [31:0]      sb_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      for (int k = 0; k < FD; k++) m_fifo[i][k] = '0;
      m_cnt[i] = 0; m_dout[i] = '0; m_prev[i] = '0; m_ctrl[i] = '0;
      m_ovf[i] = 1'b0; m_chg[i] = 1'b0;
    end
    m_out = '0; m_irq = 1'b0; m_rdata = '0;
  endtask

  task automatic model_step(input logic [31:0] a, input logic rd, input logic wr,
                            input logic [31:0] wd, input logic [NP*PW-1:0] in,
                            output logic [31:0] rexp, output bit rv);
    bit mapped;
    int p, r;
    logic nirq;
    logic [PW-1:0] v;
    bit set_chg [NP];
    bit set_ovf [NP];
    mapped = (a[31:8] == 0) && (a[1:0] == 0) && (int'(a[7:4]) < NP);
    p = int'(a[7:4]);
    r = int'(a[3:2]);
    nirq = 1'b0;
    for (int i = 0; i < NP; i++)
      nirq |= (m_chg[i] & m_ctrl[i][2]) | (m_ovf[i] & m_ctrl[i][3]);
    rv = rd && !wr;
    rexp = 0;
    if (rv && mapped) begin
      case (r)
        0: rexp = (m_cnt[p] > 0) ? 32'(m_fifo[p][0]) : 0;
        1: rexp = 32'(m_dout[p]);
        2: rexp = 32'(m_ctrl[p]);
        default: rexp = ((m_cnt[p] > 15 ? 15 : m_cnt[p]) << 4) | (32'(m_chg[p]) << 3) |
                        (32'(m_ovf[p]) << 2) | ((m_cnt[p] == FD) ? 2 : 0) |
                        ((m_cnt[p] > 0) ? 1 : 0);
      endcase
    end
    if (rv) m_rdata = rexp;
    if (rv && mapped && r == 0 && m_cnt[p] > 0) begin
      for (int k = 0; k < FD - 1; k++) m_fifo[p][k] = m_fifo[p][k+1];
      m_cnt[p]--;
    end
    for (int i = 0; i < NP; i++) begin
      v = in[i*PW +: PW];
      set_chg[i] = 0; set_ovf[i] = 0;
      if (m_ctrl[i][1] && v != m_prev[i]) begin
        set_chg[i] = 1;
        if (m_cnt[i] < FD) begin m_fifo[i][m_cnt[i]] = v; m_cnt[i]++; end
        else set_ovf[i] = 1;
      end
      m_prev[i] = v;
    end
    if (wr && mapped) begin
      case (r)
        1: m_dout[p] = wd[PW-1:0];
        2: m_ctrl[p] = wd[3:0];
        3: begin
          if (wd[2]) m_ovf[p] = 1'b0;
          if (wd[3]) m_chg[p] = 1'b0;
        end
        default: ;
      endcase
    end
    for (int i = 0; i < NP; i++) begin
      if (set_chg[i]) m_chg[i] = 1'b1;
      if (set_ovf[i]) m_ovf[i] = 1'b1;
      m_out[i*PW +: PW] = m_ctrl[i][0] ? m_dout[i] : '0;
    end
    m_irq = nirq;
  endtask

  // One bus cycle, driven from a negedge; returns at the following negedge.
  task automatic cycle(input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input bit use_exp, input logic [31:0] exp);
    logic [31:0] rexp;
    bit rv;
    io_addr = a; io_read = rd; io_write = wr; io_wdata = wd; io_in = cur_in;
    model_step(a, rd, wr, wd, cur_in, rexp, rv);
    if (rv) sb_q.push_back(use_exp ? exp : rexp);
    @(posedge clk); #1;
    check("io_out", 64'(io_out), 64'(m_out));
    check("io_irq", 64'(io_irq), 64'(m_irq));
    check("rdata_hold", 64'(io_rdata), 64'(m_rdata));
    @(negedge clk);
    io_read = 1'b0; io_write = 1'b0;
  endtask

  task automatic idle();                                   cycle(32'h0, 0, 0, 0, 0, 0);  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); cycle(a, 0, 1, d, 0, 0); endtask
  task automatic rd_exp(input logic [31:0] a, input logic [31:0] e); cycle(a, 1, 0, 0, 1, e); endtask

  // Read monitor: pops one expectation per accepted read strobe.
  initial begin
    forever begin
      @(posedge clk);
      if (reset === 1'b1 && io_read === 1'b1 && io_write === 1'b0) begin
        #1;
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_underflow: got read data 0x%0h, expected no read", io_rdata);
        end else begin
          check("read_data", 64'(io_rdata), 64'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    logic rdb, wrb;
    reset = 1'b0; io_addr = '0; io_write = 1'b0; io_read = 1'b1; io_wdata = '0;
    io_in = '0; cur_in = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      io_in = NP*PW'($urandom);
      @(posedge clk); #1;
      check("rst_rdata", 64'(io_rdata), 64'h0);
      check("rst_irq", 64'(io_irq), 64'h0);
      check("rst_out", 64'(io_out), 64'h0);
      @(negedge clk);
    end
    io_read = 1'b0; io_in = '0;
    reset = 1'b1;

    for (int p = 0; p < NP; p++) rd_exp(32'(p*16 + 12), 32'h00);

    wr(32'h24, 32'h5A);
    wr(32'h28, 32'h01);
    check("p2_out_on", 64'(io_out[23:16]), 64'h5A);
    rd_exp(32'h24, 32'h5A);
    wr(32'h28, 32'h00);
    check("p2_out_off", 64'(io_out[23:16]), 64'h00);

    wr(32'h08, 32'h06);
    cur_in[7:0] = 8'h11; idle();
    cur_in[7:0] = 8'h22; idle();
    idle();
    check("p0_irq_set", 64'(io_irq), 64'h1);
    rd_exp(32'h0C, 32'h29);
    rd_exp(32'h00, 32'h11);
    rd_exp(32'h00, 32'h22);
    wr(32'h0C, 32'h08);
    idle();
    check("p0_irq_clr", 64'(io_irq), 64'h0);

    wr(32'h18, 32'h0A);
    for (int v = 8'h31; v <= 8'h35; v++) begin cur_in[15:8] = 8'(v); idle(); end
    idle();
    check("p1_irq_ovf", 64'(io_irq), 64'h1);
    rd_exp(32'h1C, 32'h4F);
    wr(32'h1C, 32'h04);
    cur_in[15:8] = 8'h36;
    rd_exp(32'h10, 32'h31);
    rd_exp(32'h1C, 32'h4B);
    rd_exp(32'h10, 32'h32);
    rd_exp(32'h10, 32'h33);
    rd_exp(32'h10, 32'h34);
    rd_exp(32'h10, 32'h36);
    rd_exp(32'h10, 32'h00);
    rd_exp(32'h1C, 32'h08);

    rd_exp(32'h0000_0140, 32'h0);
    rd_exp(32'h1000_0000, 32'h0);
    rd_exp(32'h24, 32'h5A);
    cycle(32'h04, 1, 1, 32'h77, 0, 0);
    check("rw_prio_rdata", 64'(io_rdata), 64'h5A);
    rd_exp(32'h04, 32'h77);

    for (int n = 0; n < 400; n++) begin
      a = {24'd0, 4'($urandom_range(0, NP-1)), 2'($urandom_range(0, 3)), 2'b00};
      case ($urandom_range(0, 15))
        0: a = {24'd0, 4'($urandom_range(NP, 15)), 4'd0};
        1: a = a | 32'h0000_0100;
        2: a = a | 32'h1;
        default: ;
      endcase
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) == 0) cur_in[p*PW +: PW] = PW'($urandom);
      rdb = 1'($urandom_range(0, 1));
      wrb = ($urandom_range(0, 3) == 0);
      wd  = $urandom;
      cycle(a, rdb, wrb, wd, 0, 0);
    end
    idle();
    idle();
    check("sb_drained", 64'(sb_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
